uart_tx_buffered: RTL and testbench

Parametrised UART transmitter with an integrated write FIFO. It is the next generation of the lab UART transmitter. Data width, parity mode, stop-bit count, baud divisor and buffer depth are configurable, and the block emits back-to-back frames with no idle gap while the FIFO holds data. It sits between a host-side word source (switches, keys or a CPU register) and the serial `tx` pin, and pairs with the existing receiver.

---
 rtl/uart_tx_buffered.sv | 206 ++++++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a circular write FIFO feeding a start/data/parity/stop
// serialiser that chains frames back-to-back while words are queued.
module uart_tx_buffered #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [DATA_W-1:0]           wr_data,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        overflow,
    output logic                        busy,
    output logic                        tx
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam int unsigned CW = $clog2(DATA_W) + 1;

    localparam logic [AW:0]   DEPTH     = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
    localparam logic [CW-1:0] BIT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              r_overflow;

    logic [DATA_W-1:0] r_shift;
    logic              r_par;
    logic [BW-1:0]     r_baud;
    logic [CW-1:0]     r_bit_cnt;
    logic              r_tx;
    logic              r_busy;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_bit_end;
    logic [DATA_W-1:0] w_head;

    assign w_full    = (r_count == DEPTH);
    assign w_empty   = (r_count == '0);
    assign w_push    = wr_en && !w_full;
    assign w_head    = r_mem[r_rd_ptr];
    assign w_bit_end = (r_baud == BAUD_LAST);

    // ---------------- FIFO ----------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            // Judged against the pre-edge fullness, so a same-cycle pop does not rescue the word
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_next = S_START;
                    w_pop        = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end && (r_bit_cnt == DATA_LAST)) begin
                    w_state_next = (PARITY != 0) ? S_PAR : S_STOP;
                end
            end
            S_PAR: begin
                if (w_bit_end) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end && (r_bit_cnt == STOP_LAST)) begin
                    if (!w_empty) begin
                        w_state_next = S_START;
                        w_pop        = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_busy <= (w_state_next != S_IDLE);

            if ((r_state == S_IDLE) || (w_state_next != r_state) || w_bit_end) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + BAUD_ONE;
            end

            if (w_state_next != r_state) begin
                r_bit_cnt <= '0;
            end else if (w_bit_end && ((r_state == S_DATA) || (r_state == S_STOP))) begin
                r_bit_cnt <= r_bit_cnt + BIT_ONE;
            end

            if (w_pop) begin
                r_shift <= w_head;
                r_par   <= (^w_head) ^ (PARITY == 2);
            end else if ((r_state == S_DATA) && w_bit_end) begin
                r_shift <= r_shift >> 1;
            end

            // Line level is chosen from the state being entered so tx stays a pure register
            case (w_state_next)
                S_START: r_tx <= 1'b0;
                S_DATA: begin
                    if (w_bit_end) begin
                        r_tx <= (r_state == S_START) ? r_shift[0] : r_shift[1];
                    end
                end
                S_PAR:   r_tx <= r_par;
                default: r_tx <= 1'b1;
            endcase
        end
    end

    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = r_count;
    assign overflow = r_overflow;
    assign busy     = r_busy;
    assign tx       = r_tx;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench: three transmitter configurations share one stimulus stream and
// are each compared every cycle against a frame-level reference model.
module tb_uart_tx_buffered;

    localparam int unsigned CPB = 4;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       wr_en   = 1'b0;
    logic [8:0] wr_data = '0;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint unsigned got, input longint unsigned exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // g=0: 8N1 depth 8; g=1: 8E1 depth 8; g=2: 7O2 depth 4
    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int unsigned DW   = (g == 2) ? 7 : 8;
        localparam int unsigned PAR  = g;
        localparam int unsigned STP  = (g == 2) ? 2 : 1;
        localparam int unsigned DEP  = (g == 2) ? 4 : 8;
        localparam int unsigned NB   = 1 + DW + ((PAR != 0) ? 1 : 0) + STP;
        localparam int unsigned FLEN = NB * CPB;
        localparam logic [8:0]  MASK = 9'((1 << DW) - 1);

        logic                   full_w, empty_w, ovf_w, busy_w, tx_w;
        logic [$clog2(DEP):0]   cnt_w;

        uart_tx_buffered #(
            .DATA_W      (DW),
            .CLKS_PER_BIT(CPB),
            .FIFO_DEPTH  (DEP),
            .PARITY      (PAR),
            .STOP_BITS   (STP)
        ) dut (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_en),
            .wr_data (wr_data[DW-1:0]),
            .full    (full_w),
            .empty   (empty_w),
            .count   (cnt_w),
            .overflow(ovf_w),
            .busy    (busy_w),
            .tx      (tx_w)
        );

        // Reference: a queue of words plus the bit pattern of the frame on the line
        // and the number of clocks elapsed since its start bit began.
        logic [8:0]  mq [$];
        bit          active = 1'b0;
        bit          movf   = 1'b0;
        int unsigned t      = 0;
        bit          fb [16];

        initial forever begin
            bit         was_full, was_empty, start;
            logic [8:0] w;
            @(posedge clk or posedge rst);
            if (rst) begin
                mq.delete();
                active = 1'b0;
                movf   = 1'b0;
                t      = 0;
            end else begin
                was_full  = (mq.size() == DEP);
                was_empty = (mq.size() == 0);
                start     = 1'b0;
                if (!active) begin
                    start = !was_empty;
                end else if (t == FLEN - 1) begin
                    if (was_empty) active = 1'b0;
                    else           start  = 1'b1;
                end else begin
                    t++;
                end
                if (start) begin
                    w = mq.pop_front();
                    fb[0] = 1'b0;
                    for (int i = 0; i < DW; i++) fb[1 + i] = w[i];
                    if (PAR != 0) fb[1 + DW] = (PAR == 1) ? (^w) : !(^w);
                    for (int i = 0; i < STP; i++) fb[1 + DW + ((PAR != 0) ? 1 : 0) + i] = 1'b1;
                    active = 1'b1;
                    t      = 0;
                end
                if (wr_en && !was_full) mq.push_back(wr_data & MASK);
                if (wr_en && was_full)  movf = 1'b1;
            end
        end

        initial forever begin
            @(negedge clk);
            check_eq($sformatf("i%0d_tx", g),       tx_w,    active ? fb[t / CPB] : 1'b1);
            check_eq($sformatf("i%0d_busy", g),     busy_w,  active);
            check_eq($sformatf("i%0d_count", g),    cnt_w,   mq.size());
            check_eq($sformatf("i%0d_full", g),     full_w,  mq.size() == DEP);
            check_eq($sformatf("i%0d_empty", g),    empty_w, mq.size() == 0);
            check_eq($sformatf("i%0d_overflow", g), ovf_w,   movf);
        end
    end

    task automatic drive(input logic en, input logic [8:0] d);
        @(negedge clk);
        wr_en   = en;
        wr_data = d;
    endtask

    function automatic logic all_idle();
        return !g_inst[0].busy_w && g_inst[0].empty_w &&
               !g_inst[1].busy_w && g_inst[1].empty_w &&
               !g_inst[2].busy_w && g_inst[2].empty_w;
    endfunction

    task automatic wait_idle(input int unsigned limit);
        int unsigned n = 0;
        while (!all_idle() && n < limit) begin
            @(negedge clk);
            n++;
        end
        check_eq("wait_idle", all_idle(), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned p;

        repeat (3) @(negedge clk);
        check_eq("rst_tx",    g_inst[0].tx_w,    1);
        check_eq("rst_busy",  g_inst[0].busy_w,  0);
        check_eq("rst_empty", g_inst[0].empty_w, 1);
        check_eq("rst_full",  g_inst[0].full_w,  0);
        check_eq("rst_count", g_inst[0].cnt_w,   0);
        check_eq("rst_ovf",   g_inst[0].ovf_w,   0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single 8N1 frame of 0x55: start bit two clocks after the push, 40 clocks busy
        drive(1'b1, 9'h055);
        drive(1'b0, 9'h000);
        check_eq("single_count1", g_inst[0].cnt_w, 1);
        check_eq("single_tx_pre", g_inst[0].tx_w,  1);
        @(negedge clk);
        check_eq("single_start",  g_inst[0].tx_w,   0);
        check_eq("single_busy",   g_inst[0].busy_w, 1);
        check_eq("single_count0", g_inst[0].cnt_w,  0);
        repeat (39) @(negedge clk);
        check_eq("single_busy_last", g_inst[0].busy_w, 1);
        @(negedge clk);
        check_eq("single_busy_end", g_inst[0].busy_w, 0);
        check_eq("single_tx_end",   g_inst[0].tx_w,   1);
        wait_idle(2000);

        // Parity word 0x07 (even -> 1 on instance 1, odd -> 0 on instance 2)
        drive(1'b1, 9'h007);
        drive(1'b0, 9'h000);
        wait_idle(2000);

        // Ten consecutive pushes: ninth fills the FIFO, tenth overflows
        for (int i = 1; i <= 10; i++) drive(1'b1, 9'(i));
        check_eq("ovf_full9",  g_inst[0].full_w, 1);
        check_eq("ovf_flag9",  g_inst[0].ovf_w,  0);
        drive(1'b0, 9'h000);
        check_eq("ovf_flag10", g_inst[0].ovf_w,  1);
        check_eq("ovf_count",  g_inst[0].cnt_w,  8);
        wait_idle(5000);

        // Two words one cycle apart (2-stop instance chains them)
        drive(1'b1, 9'h0A3);
        drive(1'b1, 9'h03C);
        drive(1'b0, 9'h000);
        wait_idle(3000);

        // Push on the exact edge instance 0 pops from STOP with count=1
        drive(1'b1, 9'h0C1);
        drive(1'b1, 9'h0C2);
        repeat (39) drive(1'b0, 9'h000);
        drive(1'b1, 9'h0C3);
        drive(1'b0, 9'h000);
        check_eq("collide_count", g_inst[0].cnt_w,  1);
        check_eq("collide_start", g_inst[0].tx_w,   0);
        check_eq("collide_busy",  g_inst[0].busy_w, 1);
        wait_idle(3000);

        // Reset in the middle of data bit 4 of the first of three queued frames
        drive(1'b1, 9'h011);
        drive(1'b1, 9'h022);
        drive(1'b1, 9'h033);
        drive(1'b0, 9'h000);
        repeat (20) @(negedge clk);
        check_eq("midrst_busy_before", g_inst[0].busy_w, 1);
        #1 rst = 1'b1;
        #1;
        check_eq("midrst_tx0",    g_inst[0].tx_w,   1);
        check_eq("midrst_count0", g_inst[0].cnt_w,  0);
        check_eq("midrst_busy0",  g_inst[0].busy_w, 0);
        check_eq("midrst_tx1",    g_inst[1].tx_w,   1);
        check_eq("midrst_count1", g_inst[1].cnt_w,  0);
        check_eq("midrst_busy1",  g_inst[1].busy_w, 0);
        check_eq("midrst_tx2",    g_inst[2].tx_w,   1);
        check_eq("midrst_count2", g_inst[2].cnt_w,  0);
        check_eq("midrst_busy2",  g_inst[2].busy_w, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (150) drive(1'b0, 9'h000);
        check_eq("midrst_quiet_tx",   g_inst[0].tx_w,   1);
        check_eq("midrst_quiet_busy", g_inst[0].busy_w, 0);

        // Randomised traffic at light, medium and heavy load
        for (int blk = 0; blk < 6; blk++) begin
            p = (blk % 3 == 0) ? 5 : ((blk % 3 == 1) ? 30 : 90);
            for (int c = 0; c < 500; c++) begin
                drive($urandom_range(0, 99) < p, 9'($urandom));
            end
        end
        drive(1'b0, 9'h000);
        wait_idle(20000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
